// File: rtl/sys_bridge_intc_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge and its interrupt controller.
// Holds the default window base addresses, the INTC register offsets, the
// interrupt source indices and a lowest-set-bit helper used by the ACTIVE register.
package sys_bridge_intc_pkg;

    localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;
    localparam logic [31:0] INTC_BASE   = 32'h0000_7F20;

    localparam int NSRC = 3;

    localparam logic [1:0] INTC_PEND   = 2'd0;
    localparam logic [1:0] INTC_MASK   = 2'd1;
    localparam logic [1:0] INTC_ACTIVE = 2'd2;
    localparam logic [1:0] ACTIVE_NONE = 2'd3;

    localparam int SRC_TIMER0 = 0;
    localparam int SRC_TIMER1 = 1;
    localparam int SRC_EXT    = 2;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TIMER0,
        SEL_TIMER1,
        SEL_INTC
    } dev_sel_e;

    // Index of the lowest-numbered set bit, ACTIVE_NONE when the vector is empty.
    function automatic logic [1:0] lowest_set(input logic [NSRC-1:0] v);
        logic [1:0] idx;
        idx = ACTIVE_NONE;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sys_bridge_intc_core.sv
// Interrupt controller register bank.
// Edge-detects the level IRQs, latches rises into PEND (write-1-to-clear),
// holds MASK, encodes ACTIVE and drives HWInt = PEND & MASK.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   irq        : level IRQs {external, timer1, timer0}
//   we         : register write strobe (already qualified by request and decode)
//   addr       : register word offset
//   wd         : write data, low NSRC bits only
//   rd         : register read data, combinational
//   hwint      : interrupt lines to CP0
module intc_core
    import sys_bridge_intc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [NSRC-1:0] wd,
    output logic [31:0]     rd,
    output logic [5:0]      hwint
);

    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] pend_masked;
    logic [1:0]      active;

    assign rise = irq & ~prev;
    assign clr  = (we && addr == INTC_PEND) ? wd : '0;

    // A rise in the same cycle as a clear of that bit leaves it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
            pend <= '0;
            mask <= '0;
        end else begin
            prev <= irq;
            pend <= (pend & ~clr) | rise;
            if (we && addr == INTC_MASK) begin
                mask <= wd;
            end
        end
    end

    assign pend_masked = pend & mask;
    assign active      = lowest_set(pend_masked);
    assign hwint       = {{(6 - NSRC){1'b0}}, pend_masked};

    always_comb begin
        rd = '0;
        case (addr)
            INTC_PEND:   rd[NSRC-1:0] = pend;
            INTC_MASK:   rd[NSRC-1:0] = mask;
            INTC_ACTIVE: rd[1:0]      = active;
            default:     rd           = '0;
        endcase
    end

endmodule

// File: rtl/sys_bridge_intc.sv
// Bridge between the CPU data-memory port and the peripheral space.
// Decodes three 16-byte windows (timer0, timer1, interrupt controller),
// fans out write enables and the register offset, and muxes read data back
// combinationally in the same cycle as the request.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   PrReq/PrWE/PrAddr/PrWD: CPU request, store flag, byte address, store data
//   PrRD, AddrErr         : read data to CPU, request outside all windows
//   DEV_Addr, DEV_WD      : register offset and store data to the timers
//   DEV0_WE, DEV1_WE      : timer write enables
//   DEV0_RD, DEV1_RD      : timer read data
//   DEV0_IRQ, DEV1_IRQ, EXT_IRQ : level interrupt sources
//   HWInt                 : interrupt lines to CP0
module sys_bridge_intc #(
    parameter logic [31:0] TIMER0_BASE = sys_bridge_intc_pkg::TIMER0_BASE,
    parameter logic [31:0] TIMER1_BASE = sys_bridge_intc_pkg::TIMER1_BASE,
    parameter logic [31:0] INTC_BASE   = sys_bridge_intc_pkg::INTC_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PrReq,
    input  logic        PrWE,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    output logic [31:0] PrRD,
    output logic        AddrErr,
    output logic [1:0]  DEV_Addr,
    output logic [31:0] DEV_WD,
    output logic        DEV0_WE,
    output logic        DEV1_WE,
    input  logic [31:0] DEV0_RD,
    input  logic [31:0] DEV1_RD,
    input  logic        DEV0_IRQ,
    input  logic        DEV1_IRQ,
    input  logic        EXT_IRQ,
    output logic [5:0]  HWInt
);
    import sys_bridge_intc_pkg::*;

    logic        hit0;
    logic        hit1;
    logic        hit_intc;
    dev_sel_e    sel;
    logic [31:0] intc_rd;
    logic        unused_addr_lsb;

    // Byte-lane bits carry no meaning for word registers.
    assign unused_addr_lsb = ^PrAddr[1:0];

    assign hit0     = PrReq && (PrAddr[31:4] == TIMER0_BASE[31:4]);
    assign hit1     = PrReq && (PrAddr[31:4] == TIMER1_BASE[31:4]);
    assign hit_intc = PrReq && (PrAddr[31:4] == INTC_BASE[31:4]);

    always_comb begin
        sel = SEL_NONE;
        if (hit0) begin
            sel = SEL_TIMER0;
        end else if (hit1) begin
            sel = SEL_TIMER1;
        end else if (hit_intc) begin
            sel = SEL_INTC;
        end
    end

    assign AddrErr  = PrReq && (sel == SEL_NONE);
    assign DEV0_WE  = hit0 && PrWE;
    assign DEV1_WE  = hit1 && PrWE;
    assign DEV_Addr = PrAddr[3:2];
    assign DEV_WD   = PrWD;

    intc_core u_intc (
        .clk   (clk),
        .reset (reset),
        .irq   ({EXT_IRQ, DEV1_IRQ, DEV0_IRQ}),
        .we    (hit_intc && PrWE),
        .addr  (PrAddr[3:2]),
        .wd    (PrWD[NSRC-1:0]),
        .rd    (intc_rd),
        .hwint (HWInt)
    );

    always_comb begin
        PrRD = '0;
        case (sel)
            SEL_TIMER0: PrRD = DEV0_RD;
            SEL_TIMER1: PrRD = DEV1_RD;
            SEL_INTC:   PrRD = intc_rd;
            default:    PrRD = '0;
        endcase
    end

endmodule

// File: tb/tb_sys_bridge_intc.sv
// Self-checking bench for sys_bridge_intc: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// peripheral map and interrupt controller.
module tb_sys_bridge_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic        PrReq;
    logic        PrWE;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        AddrErr;
    logic [1:0]  DEV_Addr;
    logic [31:0] DEV_WD;
    logic        DEV0_WE;
    logic        DEV1_WE;
    logic [31:0] DEV0_RD;
    logic [31:0] DEV1_RD;
    logic        DEV0_IRQ;
    logic        DEV1_IRQ;
    logic        EXT_IRQ;
    logic [5:0]  HWInt;

    always #5 clk = ~clk;

    sys_bridge_intc dut (
        .clk      (clk),
        .reset    (reset),
        .PrReq    (PrReq),
        .PrWE     (PrWE),
        .PrAddr   (PrAddr),
        .PrWD     (PrWD),
        .PrRD     (PrRD),
        .AddrErr  (AddrErr),
        .DEV_Addr (DEV_Addr),
        .DEV_WD   (DEV_WD),
        .DEV0_WE  (DEV0_WE),
        .DEV1_WE  (DEV1_WE),
        .DEV0_RD  (DEV0_RD),
        .DEV1_RD  (DEV1_RD),
        .DEV0_IRQ (DEV0_IRQ),
        .DEV1_IRQ (DEV1_IRQ),
        .EXT_IRQ  (EXT_IRQ),
        .HWInt    (HWInt)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: what the controller should hold.
    bit [2:0]    pend_m;
    bit [2:0]    mask_m;
    bit [2:0]    prev_m;
    bit          model_ok = 1'b0;

    // Values applied to the level inputs at the next apply().
    bit [2:0]    next_irq = 3'b000;
    logic [31:0] next_rd0 = 32'h0;
    logic [31:0] next_rd1 = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 timer0, 1 timer1, 2 intc, 3 outside every window
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h7F00 && a < 32'h7F10) return 0;
        if (a >= 32'h7F10 && a < 32'h7F20) return 1;
        if (a >= 32'h7F20 && a < 32'h7F30) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] active_of(input bit [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return 32'(i);
        end
        return 32'd3;
    endfunction

    task automatic check_model();
        int          r;
        logic [31:0] erd;
        bit [2:0]    pm;
        r   = PrReq ? region(PrAddr) : 4;
        pm  = pend_m & mask_m;
        erd = 32'h0;
        if (r == 0) erd = next_rd0;
        if (r == 1) erd = next_rd1;
        if (r == 2) begin
            case (PrAddr[3:2])
                2'd0:    erd = {29'h0, pend_m};
                2'd1:    erd = {29'h0, mask_m};
                2'd2:    erd = active_of(pm);
                default: erd = 32'h0;
            endcase
        end
        check("PrRD", PrRD, erd);
        check("AddrErr", 32'(AddrErr), 32'(r == 3));
        check("DEV0_WE", 32'(DEV0_WE), 32'(r == 0 && PrWE));
        check("DEV1_WE", 32'(DEV1_WE), 32'(r == 1 && PrWE));
        check("DEV_Addr", 32'(DEV_Addr), 32'(PrAddr[3:2]));
        check("DEV_WD", DEV_WD, PrWD);
        check("HWInt", 32'(HWInt), {29'h0, pm});
    endtask

    task automatic apply(input bit rst, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        reset    = rst;
        PrReq    = req;
        PrWE     = we;
        PrAddr   = addr;
        PrWD     = wd;
        DEV0_IRQ = next_irq[0];
        DEV1_IRQ = next_irq[1];
        EXT_IRQ  = next_irq[2];
        DEV0_RD  = next_rd0;
        DEV1_RD  = next_rd1;
        #1;
        if (model_ok) check_model();
    endtask

    task automatic tick();
        bit [2:0] irq;
        bit       intc_wr;
        @(posedge clk);
        irq     = {EXT_IRQ, DEV1_IRQ, DEV0_IRQ};
        intc_wr = PrReq && PrWE && region(PrAddr) == 2;
        if (reset) begin
            pend_m   = 3'b000;
            mask_m   = 3'b000;
            prev_m   = 3'b000;
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (irq[i] && !prev_m[i]) pend_m[i] = 1'b1;
                else if (intc_wr && PrAddr[3:2] == 2'd0 && PrWD[i]) pend_m[i] = 1'b0;
            end
            if (intc_wr && PrAddr[3:2] == 2'd1) mask_m = PrWD[2:0];
            prev_m = irq;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          pick;

        // Reset
        apply(1, 0, 0, 32'h0, 32'h0); tick();
        apply(1, 0, 0, 32'h0, 32'h0); tick();
        apply(0, 0, 0, 32'h0, 32'h0);
        check("reset_hwint", 32'(HWInt), 32'h0);
        tick();

        // Timer0 store decode
        apply(0, 1, 1, 32'h7F04, 32'd100);
        check("t0_we", 32'(DEV0_WE), 32'h1);
        check("t0_we1", 32'(DEV1_WE), 32'h0);
        check("t0_addr", 32'(DEV_Addr), 32'h1);
        check("t0_wd", DEV_WD, 32'd100);
        tick();

        // Timer1 load, same-cycle data
        next_rd1 = 32'h55;
        apply(0, 1, 0, 32'h7F18, 32'h0);
        check("t1_rd", PrRD, 32'h55);
        tick();

        // Out-of-window load
        apply(0, 1, 0, 32'h7F30, 32'h0);
        check("err_flag", 32'(AddrErr), 32'h1);
        check("err_rd", PrRD, 32'h0);
        check("err_we", 32'({DEV0_WE, DEV1_WE}), 32'h0);
        tick();

        // Timer1 edge with MASK=011, then W1C while level stays high
        apply(0, 1, 1, 32'h7F24, 32'h3); tick();
        next_irq = 3'b010;
        apply(0, 0, 0, 32'h0, 32'h0); tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("pend_t1", PrRD, 32'h2);
        check("hw_t1", 32'(HWInt), 32'h2);
        tick();
        apply(0, 1, 0, 32'h7F28, 32'h0);
        check("active_t1", PrRD, 32'h1);
        tick();
        apply(0, 1, 1, 32'h7F20, 32'h2); tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("pend_clr", PrRD, 32'h0);
        check("hw_clr", 32'(HWInt), 32'h0);
        tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("pend_hold", PrRD, 32'h0);
        tick();

        // External edge while masked, then unmask
        next_irq = 3'b110;
        apply(0, 0, 0, 32'h0, 32'h0); tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("pend_ext", PrRD, 32'h4);
        check("hw_masked", 32'(HWInt), 32'h0);
        tick();
        apply(0, 1, 1, 32'h7F24, 32'h4); tick();
        apply(0, 1, 0, 32'h7F28, 32'h0);
        check("active_ext", PrRD, 32'h2);
        check("hw_ext", 32'(HWInt), 32'h4);
        tick();

        // Rise and W1C on the same bit in the same cycle: rise wins
        next_irq = 3'b111;
        apply(0, 1, 1, 32'h7F20, 32'h1); tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("set_wins", PrRD, 32'h5);
        tick();

        // Timer0 and timer1 both pending and unmasked: lowest wins
        next_irq = 3'b101;
        apply(0, 0, 0, 32'h0, 32'h0); tick();
        next_irq = 3'b111;
        apply(0, 0, 0, 32'h0, 32'h0); tick();
        apply(0, 1, 1, 32'h7F24, 32'h3); tick();
        apply(0, 1, 0, 32'h7F28, 32'h0);
        check("active_lo", PrRD, 32'h0);
        check("hw_both", 32'(HWInt), 32'h3);
        tick();

        // Reset mid-operation with PEND=111; timer0 held high through it
        next_irq = 3'b001;
        apply(1, 0, 0, 32'h0, 32'h0); tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("rst_pend", PrRD, 32'h0);
        check("rst_hw", 32'(HWInt), 32'h0);
        tick();
        apply(0, 1, 0, 32'h7F20, 32'h0);
        check("post_rst_pend", PrRD, 32'h1);
        tick();
        apply(0, 1, 0, 32'h7F24, 32'h0);
        check("post_rst_mask", PrRD, 32'h0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(7) == 0) next_irq[i] = ~next_irq[i];
            end
            next_rd0 = $urandom;
            next_rd1 = $urandom;
            pick = $urandom_range(5);
            case (pick)
                0:       a = 32'h7F00 + $urandom_range(15);
                1:       a = 32'h7F10 + $urandom_range(15);
                2, 3, 4: a = 32'h7F20 + $urandom_range(15);
                default: a = $urandom;
            endcase
            wd = $urandom;
            apply($urandom_range(59) == 0, $urandom_range(3) != 0,
                  1'($urandom_range(1)), a, wd);
            tick();
        end

        apply(0, 0, 0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
